// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central stall/flush sequencer for the 5-stage pipeline. Merges the ID-stage
// RAW hazard flag, the EXE-stage taken-branch signal and the MEM-stage SRAM
// handshake into per-register freeze/flush controls. A small FSM freezes the
// whole pipe while a multi-cycle memory access is outstanding, with a
// watchdog that forces release after TIMEOUT wait cycles.
//
// Optional feature macro: STALL_STATS_EN
//   When defined, three saturating statistics counters of width PERF_W are
//   added (hazard stall cycles, memory freeze cycles, branch flush cycles).
//   When undefined the counters and their ports do not exist.
//
// All outputs are Mealy (state plus current inputs) and are forced to zero
// during any cycle in which rst is high.

module pipeline_stall_controller #(
    parameter int TIMEOUT = 64
`ifdef STALL_STATS_EN
    ,
    parameter int PERF_W  = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        mem_start,
    output logic        freeze_if,
    output logic        flush_if,
    output logic        flush_id,
    output logic        freeze_all,
    output logic        mem_error,
    output logic [1:0]  state
`ifdef STALL_STATS_EN
    ,
    output logic [PERF_W-1:0] hazard_stalls,
    output logic [PERF_W-1:0] mem_stall_cycles,
    output logic [PERF_W-1:0] branch_flushes
`endif
);

    // ------------------------------------------------------------------
    // State encoding; 2'd3 is unreachable and simply recovers to RUN.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_RELEASE  = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

    // The wait counter only has to reach TIMEOUT-1, so clog2 bits suffice.
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mem_error_q;
    logic             mem_error_d;

    // Hazard/branch resolution, used whenever the pipe is not frozen.
    logic hb_freeze_if;
    logic hb_flush_if;
    logic hb_flush_id;

    // Branch wins over a hazard: the instruction that caused the hazard is
    // on the wrong path and is flushed anyway, so no freeze is needed.
    always_comb begin
        hb_freeze_if = 1'b0;
        hb_flush_if  = 1'b0;
        hb_flush_id  = 1'b0;
        if (branch_taken) begin
            hb_flush_if = 1'b1;
            hb_flush_id = 1'b1;
        end else if (hazard) begin
            hb_freeze_if = 1'b1;
            hb_flush_id  = 1'b1;
        end
    end

    // State, wait counter and sticky error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    // Next-state logic and Mealy outputs; everything is held low in reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_error_d = mem_error_q;
        mem_start   = 1'b0;
        freeze_if   = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        freeze_all  = 1'b0;

        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (mem_req) begin
                        // Launch the access and freeze everything right away
                        // so the load/store stays parked in MEM.
                        mem_start  = 1'b1;
                        freeze_all = 1'b1;
                        state_d    = ST_MEM_WAIT;
                        cnt_d      = '0;
                    end else begin
                        freeze_if = hb_freeze_if;
                        flush_if  = hb_flush_if;
                        flush_id  = hb_flush_id;
                    end
                end

                ST_MEM_WAIT: begin
                    // Hazard/branch inputs are held by the frozen registers
                    // and get acted on once the pipe is released.
                    freeze_all = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    if (mem_ready) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_error_d = 1'b1;
                        state_d     = ST_RELEASE;
                        cnt_d       = '0;
                    end
                end

                ST_RELEASE: begin
                    // The same memory instruction is still in MEM this cycle,
                    // so its mem_req must not restart the access.
                    freeze_if = hb_freeze_if;
                    flush_if  = hb_flush_if;
                    flush_id  = hb_flush_id;
                    state_d   = ST_RUN;
                end

                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Debug/status outputs read back zero while reset is asserted.
    assign state     = rst ? 2'd0 : state_q;
    assign mem_error = mem_error_q & ~rst;

`ifdef STALL_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: index 0 = hazard-only freeze_if cycles, 1 = freeze_all
    // cycles, 2 = branch flush cycles. Each counter saturates at all-ones.
    // ------------------------------------------------------------------
    logic [2:0]             stat_event;
    logic [2:0][PERF_W-1:0] stat_val;

    assign stat_event = {flush_if, freeze_all, freeze_if};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stat
            logic [PERF_W-1:0] count_q;

            // Saturating event counter, cleared by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    count_q <= '0;
                end else if (stat_event[gi] && (count_q != {PERF_W{1'b1}})) begin
                    count_q <= count_q + 1'b1;
                end
            end

            assign stat_val[gi] = count_q;
        end
    endgenerate

    assign hazard_stalls    = rst ? '0 : stat_val[0];
    assign mem_stall_cycles = rst ? '0 : stat_val[1];
    assign branch_flushes   = rst ? '0 : stat_val[2];
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller: directed scenarios with literal
// expectations plus a long randomized run checked every cycle against a
// behavioural model of the stall/flush rules.

module tb_pipeline_stall_controller;

    localparam int TIMEOUT = 64;
    localparam int PERF_W  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       hazard;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       mem_start;
    logic       freeze_if;
    logic       flush_if;
    logic       flush_id;
    logic       freeze_all;
    logic       mem_error;
    logic [1:0] state;
`ifdef STALL_STATS_EN
    logic [PERF_W-1:0] hazard_stalls;
    logic [PERF_W-1:0] mem_stall_cycles;
    logic [PERF_W-1:0] branch_flushes;
`endif

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .TIMEOUT (TIMEOUT)
`ifdef STALL_STATS_EN
        ,
        .PERF_W  (PERF_W)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .mem_start    (mem_start),
        .freeze_if    (freeze_if),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .freeze_all   (freeze_all),
        .mem_error    (mem_error),
        .state        (state)
`ifdef STALL_STATS_EN
        ,
        .hazard_stalls    (hazard_stalls),
        .mem_stall_cycles (mem_stall_cycles),
        .branch_flushes   (branch_flushes)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: is an access outstanding, how long has it waited,
    // is this the one release cycle after it, and has a timeout happened.
    bit m_busy    = 1'b0;
    bit m_release = 1'b0;
    int m_waited  = 0;
    bit m_err     = 1'b0;
    int m_hs = 0, m_ms = 0, m_bf = 0;
    int stat_max = (1 << PERF_W) - 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the edge, compare at the falling
    // edge against the model, then advance the model.
    task automatic step(input bit h, input bit b, input bit req, input bit rdy, input bit r);
        bit e_start, e_fif, e_flif, e_flid, e_fall, e_err;
        int e_state;
        bit hb_active;
        @(posedge clk);
        #1;
        hazard       = h;
        branch_taken = b;
        mem_req      = req;
        mem_ready    = rdy;
        rst          = r;
        @(negedge clk);

        e_start = 0; e_fif = 0; e_flif = 0; e_flid = 0; e_fall = 0; e_err = 0;
        e_state = 0;
        hb_active = 0;
        if (!r) begin
            e_err   = m_err;
            e_state = m_busy ? 1 : (m_release ? 2 : 0);
            if (m_busy) begin
                e_fall = 1;
            end else if (!m_release && req) begin
                e_start = 1;
                e_fall  = 1;
            end else begin
                hb_active = 1;
            end
            if (hb_active) begin
                if (b) begin
                    e_flif = 1;
                    e_flid = 1;
                end else if (h) begin
                    e_fif  = 1;
                    e_flid = 1;
                end
            end
        end

        chk("mem_start",  mem_start,  e_start);
        chk("freeze_if",  freeze_if,  e_fif);
        chk("flush_if",   flush_if,   e_flif);
        chk("flush_id",   flush_id,   e_flid);
        chk("freeze_all", freeze_all, e_fall);
        chk("mem_error",  mem_error,  e_err);
        chk("state",      state,      e_state);
        chk("freeze_vs_flush", freeze_all & (flush_if | flush_id), 0);
`ifdef STALL_STATS_EN
        chk("hazard_stalls",    hazard_stalls,    r ? 0 : m_hs);
        chk("mem_stall_cycles", mem_stall_cycles, r ? 0 : m_ms);
        chk("branch_flushes",   branch_flushes,   r ? 0 : m_bf);
`endif

        if (r) begin
            m_busy = 0; m_release = 0; m_waited = 0; m_err = 0;
            m_hs = 0; m_ms = 0; m_bf = 0;
        end else begin
            if (e_fif  && m_hs < stat_max) m_hs++;
            if (e_fall && m_ms < stat_max) m_ms++;
            if (e_flif && m_bf < stat_max) m_bf++;
            if (m_busy) begin
                m_waited++;
                if (rdy) begin
                    m_busy = 0; m_release = 1;
                end else if (m_waited == TIMEOUT) begin
                    m_busy = 0; m_release = 1; m_err = 1;
                end
            end else if (m_release) begin
                m_release = 0;
            end else if (req) begin
                m_busy = 1; m_waited = 0;
            end
        end
    endtask

    int waits;
    int starts;
    int fall_cnt;

    initial begin
        rst = 1'b1; hazard = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;

        // Reset held two cycles, with noisy inputs.
        step(1, 1, 1, 1, 1);
        step(1, 0, 1, 0, 1);
        chk("rst_state", state, 0);
        chk("rst_outputs", {mem_start, freeze_if, flush_if, flush_id, freeze_all, mem_error}, 0);

        // Hazard alone in RUN.
        step(1, 0, 0, 0, 0);
        chk("hazard_freeze_if", freeze_if, 1);
        chk("hazard_flush_id", flush_id, 1);
        chk("hazard_flush_if", flush_if, 0);

        // Hazard plus branch: branch wins.
        step(1, 1, 0, 0, 0);
        chk("branch_flush_if", flush_if, 1);
        chk("branch_flush_id", flush_id, 1);
        chk("branch_freeze_if", freeze_if, 0);

        // Memory access, ready three cycles after the start pulse.
        starts = 0; fall_cnt = 0;
        step(0, 0, 1, 0, 0);
        starts += mem_start; fall_cnt += freeze_all;
        step(1, 0, 1, 0, 0);
        starts += mem_start; fall_cnt += freeze_all;
        step(0, 1, 1, 0, 0);
        starts += mem_start; fall_cnt += freeze_all;
        step(0, 0, 1, 1, 0);
        starts += mem_start; fall_cnt += freeze_all;
        chk("access_freeze_cycles", fall_cnt, 4);
        step(1, 0, 1, 0, 0);
        starts += mem_start;
        chk("release_state", state, 2);
        chk("release_freeze_all", freeze_all, 0);
        chk("release_hazard_freeze_if", freeze_if, 1);
        chk("access_start_pulses", starts, 1);
        step(0, 0, 0, 0, 0);
        chk("after_release_state", state, 0);

        // Watchdog timeout with no ready.
        step(0, 0, 1, 0, 0);
        waits = 0;
        for (int i = 0; i < TIMEOUT + 16; i++) begin
            step(0, 0, 1, 0, 0);
            if (state == 2'd1) waits++;
            else break;
        end
        chk("timeout_wait_cycles", waits, TIMEOUT);
        chk("timeout_release_state", state, 2);
        chk("timeout_no_restart", mem_start, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("mem_error_sticky", mem_error, 1);

        // Reset in the middle of a wait, then a full-length timeout again.
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 0);
        chk("mid_wait_state", state, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("post_rst_state", state, 0);
        chk("post_rst_mem_error", mem_error, 0);
        step(0, 0, 1, 0, 0);
        waits = 0;
        for (int i = 0; i < TIMEOUT + 16; i++) begin
            step(0, 0, 0, 0, 0);
            if (state == 2'd1) waits++;
            else break;
        end
        chk("post_rst_timeout_cycles", waits, TIMEOUT);

        // Randomized traffic, with occasional stuck-memory bursts and resets.
        for (int seg = 0; seg < 40; seg++) begin
            if (seg % 8 == 7) begin
                for (int i = 0; i < TIMEOUT + 10; i++)
                    step($urandom_range(0, 1), $urandom_range(0, 1), 1, 0, 0);
            end else begin
                for (int i = 0; i < 150; i++)
                    step(($urandom % 3) == 0, ($urandom % 5) == 0, ($urandom % 4) == 0,
                         ($urandom % 6) == 0, ($urandom % 300) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
